// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - pipeline hazard, scoreboard and exception drain controller
//
// Purpose:
//   Sits beside the decoder of the 5-stage core. Resolves EX/MEM/WB operand
//   forwarding, load-use bubbles, RAW/WAW hazards against multi-cycle (MC)
//   writers tracked in a register scoreboard, the in-flight MC op limit,
//   branch/jump flushes, and the exception drain/redirect sequence.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   rs1/rs2/rd_addr_id_i, rd_wen_id_i,
//   mc_op_id_i, jump_id_i            instruction currently in ID
//   rd_addr_{ex,mem,wb}_i            destination registers further down the pipe
//   reg_alu_wen_{ex,mem,wb}_i        ALU-result write enables
//   reg_mem_wen_{ex,mem,wb}_i        load-result write enables
//   mc_issue_i, mc_issue_rd_i        MC op enters the MC unit
//   mc_done_i, mc_done_rd_i          MC unit writes back
//   branch_decision_ex_i             taken branch resolved in EX
//   exc_mem_i                        exception raised in MEM
//   fwd_op1_o, fwd_op2_o             forwarding selects (0 none .. 5 WB_RDATA)
//   stall_*_o, flush_*_o             stage hold / bubble strobes
//   redirect_o                       one-cycle fetch-from-trap-vector pulse
//   busy_o                           exception sequence in progress
//   outstanding_o                    in-flight MC op count

module hazard_scoreboard_ctrl #(
    parameter int NUM_REGS        = 32,
    parameter int ADDR_W          = $clog2(NUM_REGS),
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs1_addr_id_i,
    input  logic [ADDR_W-1:0] rs2_addr_id_i,
    input  logic [ADDR_W-1:0] rd_addr_id_i,
    input  logic              rd_wen_id_i,
    input  logic              mc_op_id_i,
    input  logic              jump_id_i,
    input  logic [ADDR_W-1:0] rd_addr_ex_i,
    input  logic [ADDR_W-1:0] rd_addr_mem_i,
    input  logic [ADDR_W-1:0] rd_addr_wb_i,
    input  logic              reg_alu_wen_ex_i,
    input  logic              reg_alu_wen_mem_i,
    input  logic              reg_alu_wen_wb_i,
    input  logic              reg_mem_wen_ex_i,
    input  logic              reg_mem_wen_mem_i,
    input  logic              reg_mem_wen_wb_i,
    input  logic              mc_issue_i,
    input  logic [ADDR_W-1:0] mc_issue_rd_i,
    input  logic              mc_done_i,
    input  logic [ADDR_W-1:0] mc_done_rd_i,
    input  logic              branch_decision_ex_i,
    input  logic              exc_mem_i,
    output logic [2:0]        fwd_op1_o,
    output logic [2:0]        fwd_op2_o,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              stall_ex_o,
    output logic              stall_mem_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic              flush_mem_o,
    output logic              flush_wb_o,
    output logic              redirect_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  outstanding_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_REDIRECT
    } state_t;

    localparam logic [2:0] FWD_NONE      = 3'd0;
    localparam logic [2:0] FWD_EX_ALU    = 3'd1;
    localparam logic [2:0] FWD_MEM_ALU   = 3'd2;
    localparam logic [2:0] FWD_MEM_RDATA = 3'd3;
    localparam logic [2:0] FWD_WB_ALU    = 3'd4;
    localparam logic [2:0] FWD_WB_RDATA  = 3'd5;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t              state;
    state_t              state_n;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic                redirect_q;
    logic                busy_q;

    logic                done_hit;
    logic                load_use;
    logic                sb_hazard;
    logic                hazard;

    logic [2:0]          fwd1_c;
    logic [2:0]          fwd2_c;
    logic                stall_if_c;
    logic                stall_id_c;
    logic                flush_id_c;
    logic                flush_ex_c;
    logic                flush_mem_c;

    // Youngest writer wins: EX, then MEM, then WB. A load in EX has no data
    // yet, so only an ALU write in EX can forward; the load-use bubble covers it.
    function automatic logic [2:0] fwd_sel(input logic [ADDR_W-1:0] rs);
        logic [2:0] sel;
        sel = FWD_NONE;
        if (rs != '0) begin
            if (reg_alu_wen_ex_i && (rd_addr_ex_i == rs)) begin
                sel = FWD_EX_ALU;
            end else if (rd_addr_mem_i == rs && reg_alu_wen_mem_i) begin
                sel = FWD_MEM_ALU;
            end else if (rd_addr_mem_i == rs && reg_mem_wen_mem_i) begin
                sel = FWD_MEM_RDATA;
            end else if (rd_addr_wb_i == rs && reg_alu_wen_wb_i) begin
                sel = FWD_WB_ALU;
            end else if (rd_addr_wb_i == rs && reg_mem_wen_wb_i) begin
                sel = FWD_WB_RDATA;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd1_c = fwd_sel(rs1_addr_id_i);
        fwd2_c = fwd_sel(rs2_addr_id_i);
    end

    // Scoreboard and outstanding counter next-state.
    // A completion for a register that is not marked busy is treated as
    // spurious and does not touch the count.
    always_comb begin
        done_hit = mc_done_i && sb[mc_done_rd_i];

        sb_n = sb;
        if (mc_done_i) begin
            sb_n[mc_done_rd_i] = 1'b0;
        end
        // Set after clear so a same-register issue wins over its completion.
        if (mc_issue_i) begin
            sb_n[mc_issue_rd_i] = 1'b1;
        end
        sb_n[0] = 1'b0;

        cnt_n = cnt;
        if (mc_issue_i && !done_hit && (cnt != MAX_CNT)) begin
            cnt_n = cnt + ONE_CNT;
        end else if (!mc_issue_i && done_hit && (cnt != '0)) begin
            cnt_n = cnt - ONE_CNT;
        end
    end

    // Hazard detection for the instruction in ID.
    always_comb begin
        load_use  = reg_mem_wen_ex_i && (rd_addr_ex_i != '0) &&
                    ((rd_addr_ex_i == rs1_addr_id_i) || (rd_addr_ex_i == rs2_addr_id_i));
        sb_hazard = sb[rs1_addr_id_i] || sb[rs2_addr_id_i] ||
                    (rd_wen_id_i && sb[rd_addr_id_i]) ||
                    (mc_op_id_i && (cnt == MAX_CNT));
        hazard    = load_use || sb_hazard;
    end

    // Exception sequencing. The drain decision looks at the count after this
    // cycle's issue/done so a completion on the exception cycle is not missed.
    always_comb begin
        state_n = state;
        case (state)
            ST_RUN: begin
                if (exc_mem_i) begin
                    state_n = (cnt_n != '0) ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                if (cnt_n == '0) begin
                    state_n = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // Stall/flush strobes. Exception beats branch beats jump/hazard stalls.
    always_comb begin
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        flush_mem_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (exc_mem_i) begin
                    flush_id_c  = 1'b1;
                    flush_ex_c  = 1'b1;
                    flush_mem_c = 1'b1;
                end else if (branch_decision_ex_i) begin
                    flush_id_c  = 1'b1;
                    flush_ex_c  = 1'b1;
                end else begin
                    flush_id_c  = jump_id_i;
                    // Hold IF/ID and inject a bubble into EX.
                    stall_if_c  = hazard;
                    stall_id_c  = hazard;
                    flush_ex_c  = hazard;
                end
            end
            ST_DRAIN: begin
                // Fetch is frozen while the MC unit empties; everything younger
                // than the trapping instruction keeps being squashed.
                stall_if_c  = 1'b1;
                flush_id_c  = 1'b1;
                flush_ex_c  = 1'b1;
                flush_mem_c = 1'b1;
            end
            ST_REDIRECT: begin
                flush_id_c  = 1'b1;
            end
            default: begin
                stall_if_c  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_RUN;
            sb         <= '0;
            cnt        <= '0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            sb         <= sb_n;
            cnt        <= cnt_n;
            redirect_q <= (state_n == ST_REDIRECT);
            busy_q     <= (state_n != ST_RUN);
        end
    end

    // Combinational strobes are forced low while reset is held so the pipeline
    // sees a quiet controller regardless of what the stages present.
    assign fwd_op1_o     = rst_i ? 3'd0 : fwd1_c;
    assign fwd_op2_o     = rst_i ? 3'd0 : fwd2_c;
    assign stall_if_o    = stall_if_c  && !rst_i;
    assign stall_id_o    = stall_id_c  && !rst_i;
    assign flush_id_o    = flush_id_c  && !rst_i;
    assign flush_ex_o    = flush_ex_c  && !rst_i;
    assign flush_mem_o   = flush_mem_c && !rst_i;
    assign stall_ex_o    = 1'b0;
    assign stall_mem_o   = 1'b0;
    assign flush_wb_o    = 1'b0;
    assign redirect_o    = redirect_q;
    assign busy_o        = busy_q;
    assign outstanding_o = cnt;

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
Next-generation pipeline hazard controller for the 5-stage core. It keeps EX/MEM/WB operand forwarding and load-use stalling. It adds a register scoreboard for variable-latency multi-cycle (MC) writers such as the divider, an outstanding-op limit, and an exception drain/redirect FSM. It sits beside the decoder and drives the forwarding muxes, the stage stall/flush strobes and the fetch redirect.

Parameters:
NUM_REGS, 32, number of architectural GPRs; x0 is never hazarded.
ADDR_W, $clog2(NUM_REGS), register address width.
MAX_OUTSTANDING, 2, maximum in-flight MC ops (1..7).
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width.

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-high
rs1_addr_id_i, rs2_addr_id_i  in  ADDR_W  ID source registers
rd_addr_id_i  in  ADDR_W  ID destination register
rd_wen_id_i  in  1  ID instruction writes rd
mc_op_id_i  in  1  ID instruction is an MC op
jump_id_i  in  1  ID holds JAL/JALR
rd_addr_ex_i, rd_addr_mem_i, rd_addr_wb_i  in  ADDR_W  destination registers in EX/MEM/WB
reg_alu_wen_ex_i, reg_alu_wen_mem_i, reg_alu_wen_wb_i  in  1  ALU-result write enables
reg_mem_wen_ex_i, reg_mem_wen_mem_i, reg_mem_wen_wb_i  in  1  load-result write enables
mc_issue_i  in  1  MC op leaves EX into the MC unit this cycle
mc_issue_rd_i  in  ADDR_W  rd of the issuing MC op
mc_done_i  in  1  MC unit writes its result to the regfile this cycle
mc_done_rd_i  in  ADDR_W  rd of the completing MC op
branch_decision_ex_i  in  1  taken branch resolved in EX
exc_mem_i  in  1  exception raised by the instruction in MEM
fwd_op1_o, fwd_op2_o  out  3  forwarding select: 0 none, 1 EX_ALU, 2 MEM_ALU, 3 MEM_RDATA, 4 WB_ALU, 5 WB_RDATA
stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1  stage hold strobes
flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o  out  1  stage bubble strobes
redirect_o  out  1  one-cycle pulse: fetch from the trap vector
busy_o  out  1  FSM not in RUN
outstanding_o  out  CNT_W  current in-flight MC count

Behaviour:
- Reset (async): scoreboard = 0, count = 0, FSM = RUN. All stalls, flushes and redirect_o = 0. Forwarding selects = 0.
- Forwarding (combinational):
  - Per operand, priority is EX > MEM > WB.
  - EX matches only when reg_alu_wen_ex_i is set.
  - In MEM and WB, an ALU write selects *_ALU; otherwise a load write selects *_RDATA.
  - Address 0 never matches.
- Load-use: reg_mem_wen_ex_i with rd_ex equal to a nonzero rs1/rs2 gives stall_if = stall_id = 1 and flush_ex = 1 (bubble).
- Scoreboard: sb[NUM_REGS-1:0], registered; bit 0 is held at 0.
  - mc_issue_i sets sb[mc_issue_rd_i].
  - mc_done_i clears sb[mc_done_rd_i].
  - If the same register is cleared and set in one cycle, the set wins.
- Scoreboard stall: stall_if = stall_id = 1 and flush_ex = 1 when any of these holds:
  - sb[rs1] or sb[rs2] is set (RAW);
  - sb[rd_addr_id] is set with rd_wen_id_i (WAW);
  - mc_op_id_i is set and count == MAX_OUTSTANDING.
- Clear timing: sb clears on the clock edge after mc_done, so the dependent instruction sees one extra stall cycle by design. No forwarding from the MC unit.
- Outstanding counter:
  - +1 on issue, -1 on done, unchanged when both occur.
  - Saturates at 0 and at MAX_OUTSTANDING.
  - Done on a clear sb bit is ignored: no decrement.
- Control flow (RUN state):
  - jump_id_i gives flush_id = 1.
  - branch_decision_ex_i gives flush_id = flush_ex = 1 and overrides any stall_id/stall_if in the same cycle.
- Exception FSM:
  - RUN: exc_mem_i gives flush_id = flush_ex = flush_mem = 1, overriding branch, jump and stalls. Next state is DRAIN if next count != 0, else REDIRECT.
  - DRAIN: stall_if = 1, flush_id = flush_ex = flush_mem = 1. MC done events are still processed. Go to REDIRECT when count reaches 0. exc_mem_i is ignored.
  - REDIRECT: redirect_o = 1 and flush_id = 1 for exactly one cycle, then RUN.
- stall_ex_o, stall_mem_o and flush_wb_o are always 0 in this revision.
- busy_o = (state != RUN).

Test Plan:
- Forwarding priority: add x5 in EX, lw x5 in MEM, rs1 = x5 in ID -> fwd_op1 = 1. Remove the EX writer -> fwd_op1 = 3. rs1 = x0 -> 0.
- Load-use: lw x7 in EX, ID reads x7 -> stall_if = stall_id = flush_ex = 1 for 1 cycle. Next cycle fwd = 3 with no stall.
- MC RAW: issue div rd = x10, done after 6 cycles; ID reads x10 -> stall for 6 cycles plus 1. outstanding_o goes 1 -> 0.
- Outstanding limit (MAX = 2): issue x3 and x4; ID has an MC op with rd = x9 -> stall until the first done. Simultaneous issue and done keeps the count at 2.
- Exception with pending MC: count = 1, exc_mem -> flushes asserted, DRAIN with stall_if held. Done -> REDIRECT pulse for 1 cycle -> RUN. exc with count = 0 -> REDIRECT on the next cycle.
- Overrides and reset: branch taken with load-use stall -> flush_id = flush_ex = 1 and stall = 0. Assert rst_i in DRAIN -> state RUN, sb = 0, count = 0, all outputs 0 asynchronously.
